usb_tx_pkt_builder: RTL and testbench
=====================================

// Module: usb_tx_pkt_builder
// PURPOSE
//  Host-side packet assembler that sits directly upstream of the UTMI transmit path. It builds the byte stream of
//  one USB packet: token (PID+ADDR+ENDP+CRC5), data (PID+payload+CRC16) or handshake (PID only).
//  Bytes are handed over on a TX_Valid/DataIn/TX_Ready handshake. Deasserting TX_Valid after the last byte ends the packet (EOP).
// PARAMETERS
//  MAX_PAYLOAD  1023  max data-packet payload bytes; also sets the byte-counter width (clog2(MAX_PAYLOAD+1))
// PORTS
//  Clk       in   1   single clock; all logic on rising edge
//  Rst       in   1   synchronous, active-low reset
//  Start     in   1   pulse: begin packet; sampled only in IDLE
//  Pkt_Type  in   2   00 handshake, 01 token, 10 data, 11 reserved (treated as handshake)
//  PID       in   4   packet ID nibble; PID byte sent = {~PID,PID}
//  Addr      in   7   device address (token only)
//  Endp      in   4   endpoint number (token only)
//  Pl_Valid  in   1   payload byte available
//  Pl_Data   in   8   payload byte
//  Pl_Last   in   1   marks final payload byte; Pl_Valid&Pl_Last with no data = not allowed (zero-length via Pl_Last-only see below)
//  Pl_Zlp    in   1   sampled with Start: data packet has zero-length payload
//  Pl_Ready  out  1   payload byte consumed this cycle (= state DATA & TX_Ready)
//  TX_Valid  out  1   to UTMI TX
//  DataIn    out  8   to UTMI TX
//  TX_Ready  in   1   from UTMI TX: byte on DataIn accepted this cycle
//  Busy      out  1   high from cycle after accepted Start until DONE
//  Done      out  1   one-cycle pulse: packet fully handed over
//  Underrun  out  1   sticky: payload starved mid-packet; cleared by next accepted Start
// BEHAVIOUR
//  Reset (Rst=0 at edge): state IDLE. TX_Valid=0, DataIn=8'h00, Pl_Ready=0, Busy=0, Done=0, Underrun=0, CRCs preset.
//  Reset mid-packet aborts at once, no EOP byte drained.
//  IDLE: Start=1 -> latch PID/Addr/Endp/Pkt_Type/Pl_Zlp, CRC5<=5'h1F, CRC16<=16'hFFFF, go to PID.
//  Start while Busy is ignored.
//  A byte transfer occurs on any cycle with TX_Valid&TX_Ready. TX_Valid stays 1 from PID until the last byte transfers.
//  DataIn is stable while TX_Valid=1 & TX_Ready=0.
//  States and transitions (each advances on a transfer):
//   PID    : DataIn={~PID,PID}. Next state by type: handshake->DONE, token->TOK1,
//            data->DATA, or data with Pl_Zlp->CRC_LO.
//   TOK1   : DataIn={Endp[0],Addr[6:0]} -> TOK2
//   TOK2   : DataIn={~crc5[4:0],Endp[3:1]} -> DONE
//            CRC5 is computed over Addr[0..6],Endp[0..3] in LSB-first order.
//   DATA   : DataIn=Pl_Data, TX_Valid=1. On a transfer, the byte is consumed and CRC16 is updated.
//            Pl_Last=1 or byte count=MAX_PAYLOAD -> CRC_LO.
//            If TX_Ready=1 & Pl_Valid=0: set Underrun, drop TX_Valid next cycle and go to DONE (no CRC, no Done suppression).
//   CRC_LO : DataIn=~crc16[7:0] -> CRC_HI
//   CRC_HI : DataIn=~crc16[15:8] -> DONE
//   DONE   : TX_Valid=0, Done=1 for one cycle, Busy=0 -> IDLE. Earliest next Start is sampled the following cycle.
//  CRC arithmetic is reflected and serial-equivalent, one byte per cycle (8 unrolled bit steps).
//   Per bit b, LSB first: fb=crc[0]^b; crc=crc>>1; if fb, crc^=POLY.
//   CRC5 POLY=5'h14 (x^5+x^2+1); CRC16 POLY=16'hA001 (x^16+x^15+x^2+1).
//   Both CRCs are inverted on transmit.
//  Byte counter saturates at MAX_PAYLOAD; it never wraps.
//  Latency: Start -> TX_Valid=1 in 1 cycle. Last transfer -> TX_Valid=0 and Done=1 in the next cycle.
// STRUCTURE
//  Shared package usb_pkg: Pkt_Type encodings; PID constants (OUT 4'h1, IN 4'h9, SETUP 4'hD, DATA0 4'h3, DATA1 4'hB,
//   ACK 4'h2, NAK 4'hA, STALL 4'hE); CRC5/CRC16 poly and init values; FSM state enum.
//  One sub-module: usb_crc_byte (combinational next-CRC for 8 bits; parameterised width/poly), instanced once for CRC16.
//  The CRC5 uses the same function over 11 bits, computed once at latch time.
// TESTING
//  1. SETUP token, Addr=0, Endp=0, TX_Ready=1 always -> bytes 2D 00 10, then TX_Valid=0 and a Done pulse.
//  2. DATA0 with Pl_Zlp=1 -> bytes C3 00 00; Pl_Ready never asserted.
//  3. DATA1, 4-byte payload 01 02 03 04, TX_Ready toggling 1-in-3 -> 4B 01 02 03 04 + CRC16 matching the model.
//     DataIn is held stable while TX_Ready=0.
//  4. ACK handshake -> single byte D2; Done 1 cycle after the transfer; Start during Busy is ignored.
//  5. DATA0, Pl_Valid=0 after 2 bytes with TX_Ready=1 -> Underrun=1, TX_Valid drops, no CRC bytes.
//     The next Start clears Underrun.
//  6. Rst=0 during DATA -> next cycle all outputs at reset values; a fresh IN token (Addr=0x3A, Endp=0xA) emits 69 + model bytes.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared USB packet-builder definitions: packet types, PID values, CRC constants,
// FSM state encoding and the single-bit reflected CRC step used by both CRCs.
package usb_pkg;

   typedef enum logic [1:0] {
      PKT_HS    = 2'b00,
      PKT_TOKEN = 2'b01,
      PKT_DATA  = 2'b10,
      PKT_RSVD  = 2'b11
   } pkt_type_e;

   localparam logic [3:0] PID_OUT   = 4'h1;
   localparam logic [3:0] PID_IN    = 4'h9;
   localparam logic [3:0] PID_SETUP = 4'hD;
   localparam logic [3:0] PID_DATA0 = 4'h3;
   localparam logic [3:0] PID_DATA1 = 4'hB;
   localparam logic [3:0] PID_ACK   = 4'h2;
   localparam logic [3:0] PID_NAK   = 4'hA;
   localparam logic [3:0] PID_STALL = 4'hE;

   localparam logic [4:0]  CRC5_POLY  = 5'h14;
   localparam logic [4:0]  CRC5_INIT  = 5'h1F;
   localparam logic [15:0] CRC16_POLY = 16'hA001;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PID,
      ST_TOK1,
      ST_TOK2,
      ST_DATA,
      ST_CRC_LO,
      ST_CRC_HI,
      ST_DONE
   } state_e;

   // Narrower CRCs are carried zero-extended; their polys have no upper bits,
   // so the upper bits of the register stay zero through the shift.
   function automatic logic [15:0] crc_step(input logic [15:0] crc,
                                            input logic        b,
                                            input logic [15:0] poly);
      logic [15:0] nxt;
      nxt = crc >> 1;
      if (crc[0] ^ b) nxt = nxt ^ poly;
      return nxt;
   endfunction

   function automatic logic [4:0] crc5_token(input logic [6:0] addr,
                                             input logic [3:0] endp);
      logic [10:0] bits;
      logic [15:0] crc;
      bits = {endp, addr};
      crc  = {11'd0, CRC5_INIT};
      for (int i = 0; i < 11; i++) crc = crc_step(crc, bits[i], {11'd0, CRC5_POLY});
      return crc[4:0];
   endfunction

endpackage

// File: rtl/usb_crc_byte.sv
// Combinational next-CRC for one byte, LSB first, reflected; width/poly set by parameters.
module usb_crc_byte
   import usb_pkg::*;
#(
   parameter int          W    = 16,
   parameter logic [15:0] POLY = 16'hA001
) (
   input  logic [W-1:0] crc_i,
   input  logic [7:0]   data_i,
   output logic [W-1:0] crc_o
);

   logic [15:0] crc_w;

   always_comb begin
      crc_w = 16'(crc_i);
      for (int i = 0; i < 8; i++) crc_w = crc_step(crc_w, data_i[i], POLY);
      crc_o = crc_w[W-1:0];
   end

endmodule

// File: rtl/usb_tx_pkt_builder.sv
// Assembles one USB token, data or handshake packet onto the UTMI transmit handshake.
//
// state  | meaning
// IDLE   | waiting for Start
// PID    | sending {~PID,PID}
// TOK1   | sending {Endp[0],Addr}
// TOK2   | sending {~crc5,Endp[3:1]}
// DATA   | streaming payload bytes, CRC16 accumulating
// CRC_LO | sending ~crc16[7:0]
// CRC_HI | sending ~crc16[15:8]
// DONE   | TX_Valid low (EOP), one-cycle Done pulse
module usb_tx_pkt_builder
   import usb_pkg::*;
#(
   parameter int MAX_PAYLOAD = 1023
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       Start,
   input  logic [1:0] Pkt_Type,
   input  logic [3:0] PID,
   input  logic [6:0] Addr,
   input  logic [3:0] Endp,
   input  logic       Pl_Valid,
   input  logic [7:0] Pl_Data,
   input  logic       Pl_Last,
   input  logic       Pl_Zlp,
   output logic       Pl_Ready,
   output logic       TX_Valid,
   output logic [7:0] DataIn,
   input  logic       TX_Ready,
   output logic       Busy,
   output logic       Done,
   output logic       Underrun
);

   localparam int CNT_W = $clog2(MAX_PAYLOAD + 1);

   state_e          state_q, state_d;
   pkt_type_e       type_q, type_d;
   logic [3:0]      pid_q, pid_d;
   logic [6:0]      addr_q, addr_d;
   logic [3:0]      endp_q, endp_d;
   logic            zlp_q, zlp_d;
   logic [4:0]      crc5_q, crc5_d;
   logic [15:0]     crc16_q, crc16_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic            underrun_q, underrun_d;
   logic [15:0]     crc16_nxt;

   usb_crc_byte #(.W(16), .POLY(CRC16_POLY)) u_crc16 (
      .crc_i  (crc16_q),
      .data_i (Pl_Data),
      .crc_o  (crc16_nxt)
   );

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_q    <= ST_IDLE;
         type_q     <= PKT_HS;
         pid_q      <= '0;
         addr_q     <= '0;
         endp_q     <= '0;
         zlp_q      <= 1'b0;
         crc5_q     <= CRC5_INIT;
         crc16_q    <= CRC16_INIT;
         cnt_q      <= '0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         type_q     <= type_d;
         pid_q      <= pid_d;
         addr_q     <= addr_d;
         endp_q     <= endp_d;
         zlp_q      <= zlp_d;
         crc5_q     <= crc5_d;
         crc16_q    <= crc16_d;
         cnt_q      <= cnt_d;
         underrun_q <= underrun_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      type_d     = type_q;
      pid_d      = pid_q;
      addr_d     = addr_q;
      endp_d     = endp_q;
      zlp_d      = zlp_q;
      crc5_d     = crc5_q;
      crc16_d    = crc16_q;
      cnt_d      = cnt_q;
      underrun_d = underrun_q;
      TX_Valid   = 1'b0;
      DataIn     = 8'h00;
      Pl_Ready   = 1'b0;
      Done       = 1'b0;
      Busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
      Underrun   = underrun_q;

      case (state_q)
         ST_IDLE: begin
            if (Start) begin
               type_d     = pkt_type_e'(Pkt_Type);
               pid_d      = PID;
               addr_d     = Addr;
               endp_d     = Endp;
               zlp_d      = Pl_Zlp;
               crc5_d     = crc5_token(Addr, Endp);
               crc16_d    = CRC16_INIT;
               cnt_d      = '0;
               underrun_d = 1'b0;
               state_d    = ST_PID;
            end
         end
         ST_PID: begin
            TX_Valid = 1'b1;
            DataIn   = {~pid_q, pid_q};
            if (TX_Ready) begin
               case (type_q)
                  PKT_TOKEN: state_d = ST_TOK1;
                  PKT_DATA:  state_d = zlp_q ? ST_CRC_LO : ST_DATA;
                  default:   state_d = ST_DONE;
               endcase
            end
         end
         ST_TOK1: begin
            TX_Valid = 1'b1;
            DataIn   = {endp_q[0], addr_q};
            if (TX_Ready) state_d = ST_TOK2;
         end
         ST_TOK2: begin
            TX_Valid = 1'b1;
            DataIn   = {~crc5_q, endp_q[3:1]};
            if (TX_Ready) state_d = ST_DONE;
         end
         ST_DATA: begin
            TX_Valid = 1'b1;
            DataIn   = Pl_Data;
            Pl_Ready = TX_Ready;
            if (TX_Ready) begin
               // Starved source: packet is abandoned without CRC so the receiver rejects it.
               if (!Pl_Valid) begin
                  underrun_d = 1'b1;
                  state_d    = ST_DONE;
               end else begin
                  crc16_d = crc16_nxt;
                  cnt_d   = (cnt_q == CNT_W'(MAX_PAYLOAD)) ? cnt_q : cnt_q + CNT_W'(1);
                  if (Pl_Last || (cnt_q == CNT_W'(MAX_PAYLOAD - 1))) state_d = ST_CRC_LO;
               end
            end
         end
         ST_CRC_LO: begin
            TX_Valid = 1'b1;
            DataIn   = ~crc16_q[7:0];
            if (TX_Ready) state_d = ST_CRC_HI;
         end
         ST_CRC_HI: begin
            TX_Valid = 1'b1;
            DataIn   = ~crc16_q[15:8];
            if (TX_Ready) state_d = ST_DONE;
         end
         ST_DONE: begin
            Done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_usb_tx_pkt_builder.sv
// Self-checking bench for usb_tx_pkt_builder: directed scenarios plus randomized packets
// compared against a byte-list reference model.
module tb_usb_tx_pkt_builder;

   localparam int MAX_PL = 1023;

   logic       Clk = 1'b0;
   logic       Rst, Start, Pl_Valid, Pl_Last, Pl_Zlp, TX_Ready;
   logic [1:0] Pkt_Type;
   logic [3:0] PID, Endp;
   logic [6:0] Addr;
   logic [7:0] Pl_Data, DataIn;
   logic       Pl_Ready, TX_Valid, Busy, Done, Underrun;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 Clk = ~Clk;

   usb_tx_pkt_builder #(.MAX_PAYLOAD(MAX_PL)) dut (
      .Clk(Clk), .Rst(Rst), .Start(Start), .Pkt_Type(Pkt_Type), .PID(PID),
      .Addr(Addr), .Endp(Endp), .Pl_Valid(Pl_Valid), .Pl_Data(Pl_Data),
      .Pl_Last(Pl_Last), .Pl_Zlp(Pl_Zlp), .Pl_Ready(Pl_Ready), .TX_Valid(TX_Valid),
      .DataIn(DataIn), .TX_Ready(TX_Ready), .Busy(Busy), .Done(Done), .Underrun(Underrun)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reflected CRC over a bit stream in transmission order.
   function automatic logic [15:0] ref_crc(input bit bits[$], input int w,
                                           input logic [15:0] poly, input logic [15:0] init);
      logic [15:0] c;
      logic [15:0] mask;
      mask = 16'((32'd1 << w) - 1);
      c = init;
      foreach (bits[i]) begin
         if (c[0] ^ bits[i]) c = (c >> 1) ^ poly;
         else                c = c >> 1;
      end
      return c & mask;
   endfunction

   task automatic model_pkt(input logic [1:0] typ, input logic [3:0] pid, input logic [6:0] addr,
                            input logic [3:0] endp, input logic zlp, input logic [7:0] pl[$],
                            input int avail, output logic [7:0] q[$], output bit urun);
      bit          bits[$];
      logic [15:0] c;
      q = {};
      urun = 0;
      q.push_back({~pid, pid});
      if (typ == 2'b01) begin
         for (int i = 0; i < 7; i++) bits.push_back(addr[i]);
         for (int i = 0; i < 4; i++) bits.push_back(endp[i]);
         c = ref_crc(bits, 5, 16'h0014, 16'h001F);
         q.push_back({endp[0], addr});
         q.push_back({~c[4:0], endp[3:1]});
      end else if (typ == 2'b10) begin
         if (!zlp) begin
            for (int i = 0; i < pl.size(); i++) begin
               if (i >= avail) begin
                  q.push_back(8'h00);
                  urun = 1;
                  break;
               end
               q.push_back(pl[i]);
               for (int b = 0; b < 8; b++) bits.push_back(pl[i][b]);
               if (i == pl.size() - 1 || i + 1 == MAX_PL) break;
            end
         end
         if (!urun) begin
            c = ref_crc(bits, 16, 16'hA001, 16'hFFFF);
            q.push_back(~c[7:0]);
            q.push_back(~c[15:8]);
         end
      end
   endtask

   // rdy_mode: 0 always ready, 1 ready one cycle in three, 2 random
   task automatic run_pkt(input string tag, input logic [1:0] typ, input logic [3:0] pid,
                          input logic [6:0] addr, input logic [3:0] endp, input logic zlp,
                          input logic [7:0] pl[$], input int avail, input int rdy_mode,
                          input bit busy_start);
      logic [7:0] got[$];
      logic [7:0] exp[$];
      bit         urun, done_seen, holding, plr_seen;
      logic [7:0] hold_val;
      int         idx, last_x;
      model_pkt(typ, pid, addr, endp, zlp, pl, avail, exp, urun);
      done_seen = 0; holding = 0; plr_seen = 0; idx = 0; last_x = -10; hold_val = 8'h00;
      @(posedge Clk); #1;
      Start = 1'b1; Pkt_Type = typ; PID = pid; Addr = addr; Endp = endp; Pl_Zlp = zlp;
      Pl_Valid = 1'b0; Pl_Data = 8'h00; Pl_Last = 1'b0; TX_Ready = 1'b0;
      @(posedge Clk); #1;
      Pl_Zlp = 1'b0;
      for (int cyc = 0; cyc < 3000 && !done_seen; cyc++) begin
         Start    = busy_start && cyc == 1;
         PID      = (busy_start && cyc == 1) ? ~pid : pid;
         TX_Ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (cyc % 3 == 2) : 1'($urandom_range(0, 1));
         Pl_Valid = idx < avail;
         Pl_Data  = Pl_Valid ? pl[idx] : 8'h00;
         Pl_Last  = Pl_Valid && idx == pl.size() - 1;
         @(negedge Clk);
         if (cyc == 0) begin
            chk({tag, "_lat_txv"}, 32'(TX_Valid), 32'd1);
            chk({tag, "_busy"}, 32'(Busy), 32'd1);
         end
         if (holding && TX_Valid) chk({tag, "_hold"}, 32'(DataIn), 32'(hold_val));
         holding  = TX_Valid && !TX_Ready;
         hold_val = DataIn;
         if (TX_Valid && TX_Ready) begin
            got.push_back(DataIn);
            last_x = cyc;
         end
         if (Pl_Ready) plr_seen = 1;
         if (Pl_Ready && Pl_Valid) idx++;
         if (Done) begin
            done_seen = 1;
            chk({tag, "_eop_txv"}, 32'(TX_Valid), 32'd0);
            chk({tag, "_done_lat"}, 32'(cyc - last_x), 32'd1);
         end
         @(posedge Clk); #1;
      end
      Start = 1'b0; PID = pid; TX_Ready = 1'b0; Pl_Valid = 1'b0; Pl_Last = 1'b0;
      chk({tag, "_done_seen"}, 32'(done_seen), 32'd1);
      chk({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < got.size(); i++)
         chk($sformatf("%s_b%0d", tag, i), 32'(got[i]), 32'(exp[i]));
      chk({tag, "_underrun"}, 32'(Underrun), 32'(urun));
      if (!(typ == 2'b10 && !zlp)) chk({tag, "_plrdy"}, 32'(plr_seen), 32'd0);
      if (busy_start) begin
         for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            chk({tag, "_no_restart"}, 32'(TX_Valid), 32'd0);
         end
         @(posedge Clk); #1;
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_txv"}, 32'(TX_Valid), 32'd0);
      chk({tag, "_din"}, 32'(DataIn), 32'd0);
      chk({tag, "_plr"}, 32'(Pl_Ready), 32'd0);
      chk({tag, "_busy"}, 32'(Busy), 32'd0);
      chk({tag, "_done"}, 32'(Done), 32'd0);
      chk({tag, "_urun"}, 32'(Underrun), 32'd0);
   endtask

   initial begin
      logic [7:0] pl[$];
      logic [1:0] typ;
      int         len, avail;
      Rst = 1'b0; Start = 1'b0; Pkt_Type = 2'b00; PID = 4'h0; Addr = 7'h00; Endp = 4'h0;
      Pl_Valid = 1'b0; Pl_Data = 8'h00; Pl_Last = 1'b0; Pl_Zlp = 1'b0; TX_Ready = 1'b0;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      chk_reset_vals("reset");
      @(posedge Clk); #1;
      Rst = 1'b1;

      pl = {};
      run_pkt("setup", 2'b01, 4'hD, 7'h00, 4'h0, 1'b0, pl, 0, 0, 0);
      run_pkt("zlp", 2'b10, 4'h3, 7'h00, 4'h0, 1'b1, pl, 0, 0, 0);
      pl = '{8'h01, 8'h02, 8'h03, 8'h04};
      run_pkt("data1", 2'b10, 4'hB, 7'h00, 4'h0, 1'b0, pl, 4, 1, 0);
      pl = {};
      run_pkt("ack", 2'b00, 4'h2, 7'h00, 4'h0, 1'b0, pl, 0, 1, 1);
      run_pkt("rsvd", 2'b11, 4'hE, 7'h55, 4'h5, 1'b0, pl, 0, 2, 0);
      pl = '{8'hA5, 8'h5A, 8'hFF, 8'h00};
      run_pkt("urun", 2'b10, 4'h3, 7'h00, 4'h0, 1'b0, pl, 2, 0, 0);
      pl = {};
      run_pkt("nak_clr", 2'b00, 4'hA, 7'h00, 4'h0, 1'b0, pl, 0, 0, 0);

      // Abort mid-DATA with a synchronous reset, then a fresh token.
      Start = 1'b1; Pkt_Type = 2'b10; PID = 4'h3; Pl_Valid = 1'b1; Pl_Data = 8'h55;
      Pl_Last = 1'b0; TX_Ready = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      Rst = 1'b0;
      @(posedge Clk); #1;
      @(negedge Clk);
      chk_reset_vals("midrst");
      @(posedge Clk); #1;
      Rst = 1'b1; Pl_Valid = 1'b0; TX_Ready = 1'b0;
      run_pkt("in_tok", 2'b01, 4'h9, 7'h3A, 4'hA, 1'b0, pl, 0, 2, 0);

      // Payload longer than MAX_PAYLOAD with no Pl_Last: cut after MAX_PAYLOAD bytes.
      pl = {};
      for (int i = 0; i < MAX_PL + 7; i++) pl.push_back(8'($urandom));
      run_pkt("maxpl", 2'b10, 4'hB, 7'h00, 4'h0, 1'b0, pl, pl.size(), 0, 0);

      for (int k = 0; k < 16; k++) begin
         typ = 2'($urandom_range(0, 3));
         len = $urandom_range(1, 8);
         pl = {};
         for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
         avail = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len - 1) : len;
         run_pkt($sformatf("rnd%0d", k), typ, 4'($urandom), 7'($urandom), 4'($urandom),
                 1'(typ == 2'b10 && $urandom_range(0, 4) == 0), pl, avail, 2, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
